serial_result_collector: RTL and testbench
==========================================

// Module: serial_result_collector
// PURPOSE
// - Downstream of the bit-serial subtractor stage. Consumes its serial result
//   bit (S) and overflow flag (V), LSB first.
// - Assembles WIDTH consecutive valid bits into one parallel word.
// - Presents the word with a valid/ready handshake to the next stage (ALU
//   register file or display).
// PARAMETERS
// - WIDTH   4  bits per serial word; legal range 2..32
// - CNT_W   $clog2(WIDTH)  bit-counter width; derived, do not override
// PORTS
// - clk         in   1      rising-edge system clock; sole clock
// - rst         in   1      asynchronous, active-high reset
// - ser_bit     in   1      serial difference bit S, LSB first
// - ser_ovf     in   1      overflow flag V from upstream, sampled with ser_bit
// - ser_vld     in   1      ser_bit/ser_ovf valid this cycle; no backpressure
// - flush_i     in   1      synchronous discard of the partial word
// - word_o      out  WIDTH  assembled word; bit 0 = first bit received
// - ovf_o       out  1      ser_ovf captured with the word's last (MSB) bit
// - word_vld_o  out  1      word_o/ovf_o valid
// - word_rdy_i  in   1      consumer accepts; transfer when word_vld_o & word_rdy_i
// - drop_o      out  1      1-cycle pulse: a completed word was discarded
// - busy_o      out  1      partial word in progress (bit count != 0)
// BEHAVIOUR
// - Reset (async assert, sync release): all outputs, shift reg, counter,
//   holding reg = 0; FSM in IDLE.
// - FSM states:
//   - IDLE: cnt = 0. A ser_vld moves the FSM to SHIFT.
//   - SHIFT: collecting bits; stays until the WIDTH-th bit.
//   - On the last bit: word completes, FSM returns to IDLE.
// - Shift: on ser_vld, sreg <= {ser_bit, sreg[WIDTH-1:1]} and cnt++.
//   Cycles with ser_vld=0 hold all state (gaps allowed).
// - Completion: the cycle ser_vld=1 and cnt == WIDTH-1.
//   - The full word plus ser_ovf load into the holding reg.
//   - word_vld_o rises on the next edge: 1-cycle latency after the last bit.
//   - cnt wraps to 0. Back-to-back words need no idle cycle.
// - Holding reg: one entry. word_vld_o clears on handshake.
//   - word_o is stable while word_vld_o=1 and word_rdy_i=0.
// - Completion while holding full and no handshake: the new word is dropped.
//   - Old word is kept; drop_o pulses for one cycle.
// - Completion in the same cycle as a handshake: the new word loads and
//   word_vld_o stays 1 (no drop).
// - flush_i: cnt <= 0 and FSM -> IDLE; the sreg content is then irrelevant.
//   - The holding reg is untouched.
//   - flush_i has priority over ser_vld in the same cycle; that bit is lost.
// - busy_o = (cnt != 0), combinational from the registered counter.
// - Reset mid-word or mid-hold: partial and held data are lost; no drop_o pulse.
// STRUCTURE
// - Shared package `alu_pkg`:
//   - DEF_WORD_W = 4
//   - FSM state encoding: IDLE = 1'b0, SHIFT = 1'b1
// - Sub-module `ser_shift_reg`:
//   - Contains: WIDTH-bit right-shift register + counter.
//   - Ports: clk, rst, en, clr, din → q, last.
// - Top level holds the FSM, holding reg and handshake logic.
// TESTING (WIDTH=4, ser_vld=1 every cycle unless noted)
// - Bits 1,0,1,1 with ovf 0,0,0,1; word_rdy_i=1
//   → word_o=4'hD, ovf_o=1, word_vld_o high 1 cycle after 4th bit.
// - Bits 1,1,0,0 then 1,1,0,1 back-to-back; rdy=1
//   → 4'h3 then 4'hB; no idle cycle, drop_o=0.
// - rdy=0, send two words 4'hD, 4'h3
//   → word_o holds 4'hD; drop_o pulses once at the 2nd completion.
// - rdy=0 with 4'hD held; rdy=1 in the cycle word 4'h3 completes
//   → 4'hD transferred, next cycle word_o=4'h3 valid, no drop.
// - Bits 1,0 then flush_i, then 0,1,1,1 → word_o=4'hE; busy_o=0 after flush.
// - rst asserted mid-word (async, between edges)
//   → word_vld_o, busy_o, drop_o = 0 immediately; next word assembles cleanly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath: default word width and collector FSM encoding.
package alu_pkg;

    localparam int unsigned DEF_WORD_W = 4;

    // Collector FSM: IDLE means no partial word, SHIFT means bits are being gathered.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/ser_shift_reg.sv
// Right-shift register with bit counter: gathers serial bits LSB first.
module ser_shift_reg
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WORD_W,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             din,
    output logic [WIDTH-1:0] q,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [WIDTH-1:0] sreg_q;
    logic [CNT_W-1:0] cnt_q;

    // The next accepted bit completes the word.
    assign last = (cnt_q == CNT_W'(WIDTH - 1));
    assign q    = sreg_q;
    assign cnt  = cnt_q;

    // Shift in on enable; clear only resets the count, stale data is harmless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            sreg_q <= {din, sreg_q[WIDTH-1:1]};
            cnt_q  <= last ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_result_collector.sv
// Collects serial subtractor results into parallel words behind a one-entry valid/ready buffer.
module serial_result_collector
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WORD_W,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_bit,
    input  logic             ser_ovf,
    input  logic             ser_vld,
    input  logic             flush_i,
    output logic [WIDTH-1:0] word_o,
    output logic             ovf_o,
    output logic             word_vld_o,
    input  logic             word_rdy_i,
    output logic             drop_o,
    output logic             busy_o
);

    state_e           state_q, state_d;
    logic             shift_en;
    logic             complete;
    logic             handshake;
    logic [WIDTH-1:0] sr_q;
    logic [CNT_W-1:0] sr_cnt;
    logic             sr_last;
    logic [WIDTH-1:0] new_word;

    logic [WIDTH-1:0] word_q, word_d;
    logic             ovf_q, ovf_d;
    logic             hold_vld_q, hold_vld_d;
    logic             drop_q, drop_d;

    // Flush wins over a same-cycle valid bit, which is then lost.
    assign shift_en  = ser_vld & ~flush_i;
    assign complete  = (state_q == SHIFT) & shift_en & sr_last;
    assign handshake = hold_vld_q & word_rdy_i;
    // Completed word includes the bit arriving this cycle as its MSB.
    assign new_word  = {ser_bit, sr_q[WIDTH-1:1]};

    ser_shift_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shift (
        .clk  (clk),
        .rst  (rst),
        .en   (shift_en),
        .clr  (flush_i),
        .din  (ser_bit),
        .q    (sr_q),
        .cnt  (sr_cnt),
        .last (sr_last)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: enter SHIFT on the first bit, leave on the last bit or a flush.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (shift_en) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (flush_i || complete) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding register next state: load if empty or draining this cycle, else drop.
    always_comb begin
        word_d     = word_q;
        ovf_d      = ovf_q;
        hold_vld_d = hold_vld_q;
        drop_d     = 1'b0;
        if (complete) begin
            if (!hold_vld_q || word_rdy_i) begin
                word_d     = new_word;
                ovf_d      = ser_ovf;
                hold_vld_d = 1'b1;
            end else begin
                drop_d = 1'b1;
            end
        end else if (handshake) begin
            hold_vld_d = 1'b0;
        end
    end

    // Holding register and drop pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q     <= '0;
            ovf_q      <= 1'b0;
            hold_vld_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            word_q     <= word_d;
            ovf_q      <= ovf_d;
            hold_vld_q <= hold_vld_d;
            drop_q     <= drop_d;
        end
    end

    assign word_o     = word_q;
    assign ovf_o      = ovf_q;
    assign word_vld_o = hold_vld_q;
    assign drop_o     = drop_q;
    assign busy_o     = (sr_cnt != '0);

endmodule

// File: tb/tb_serial_result_collector.sv
// Directed and random stimulus for serial_result_collector against a queue-based reference model.
module tb_serial_result_collector;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         ser_bit, ser_ovf, ser_vld, flush_i, word_rdy_i;
    logic [W-1:0] word_o;
    logic         ovf_o, word_vld_o, drop_o, busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit           m_bits[$];
    logic [W-1:0] m_word;
    logic         m_ovf, m_hv, m_drop;

    serial_result_collector #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ser_bit    (ser_bit),
        .ser_ovf    (ser_ovf),
        .ser_vld    (ser_vld),
        .flush_i    (flush_i),
        .word_o     (word_o),
        .ovf_o      (ovf_o),
        .word_vld_o (word_vld_o),
        .word_rdy_i (word_rdy_i),
        .drop_o     (drop_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_word = '0;
        m_ovf  = 1'b0;
        m_hv   = 1'b0;
        m_drop = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ":word_vld"}, 32'(word_vld_o), 32'(m_hv));
        check({tag, ":word"},     32'(word_o),     32'(m_word));
        check({tag, ":ovf"},      32'(ovf_o),      32'(m_ovf));
        check({tag, ":drop"},     32'(drop_o),     32'(m_drop));
        check({tag, ":busy"},     32'(busy_o),     32'(m_bits.size() != 0));
    endtask

    // One clock: apply inputs, advance the model by the rules, compare after the edge.
    task automatic step(input string tag, input logic v, input logic b, input logic o,
                        input logic f, input logic r);
        logic         done;
        logic [W-1:0] w;
        ser_vld = v; ser_bit = b; ser_ovf = o; flush_i = f; word_rdy_i = r;
        @(posedge clk);
        done   = 1'b0;
        w      = '0;
        m_drop = 1'b0;
        if (f) begin
            m_bits.delete();
        end else if (v) begin
            m_bits.push_back(b);
            if (m_bits.size() == W) begin
                for (int i = 0; i < W; i++) w[i] = m_bits[i];
                m_bits.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (!m_hv || r) begin
                m_word = w;
                m_ovf  = o;
                m_hv   = 1'b1;
            end else begin
                m_drop = 1'b1;
            end
        end else if (m_hv && r) begin
            m_hv = 1'b0;
        end
        #1;
        check_all(tag);
    endtask

    // Send a whole word LSB first with ovf only on the MSB bit.
    task automatic send_word(input string tag, input logic [W-1:0] w, input logic ovf,
                             input logic r);
        for (int i = 0; i < W; i++) begin
            step(tag, 1'b1, w[i], (i == W - 1) ? ovf : 1'b0, 1'b0, r);
        end
    endtask

    initial begin
        rst = 1'b1;
        ser_bit = 0; ser_ovf = 0; ser_vld = 0; flush_i = 0; word_rdy_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // 1,0,1,1 with ovf on the last bit -> D, valid one edge after the 4th bit
        step("d0", 1, 1, 0, 0, 1);
        step("d1", 1, 0, 0, 0, 1);
        step("d2", 1, 1, 0, 0, 1);
        check("d2_not_yet", 32'(word_vld_o), 32'd0);
        step("d3", 1, 1, 1, 0, 1);
        check("d_word", 32'(word_o), 32'hD);
        check("d_ovf",  32'(ovf_o),  32'd1);
        step("d_drain", 0, 0, 0, 0, 1);

        // Back-to-back 3 then B, consumer always ready
        send_word("b2b_3", 4'h3, 1'b0, 1'b1);
        check("b2b_3_word", 32'(word_o), 32'h3);
        send_word("b2b_B", 4'hB, 1'b0, 1'b1);
        check("b2b_B_word", 32'(word_o), 32'hB);
        step("b2b_drain", 0, 0, 0, 0, 1);

        // Consumer stalled: second word is dropped, first retained
        send_word("stall_D", 4'hD, 1'b1, 1'b0);
        send_word("stall_3", 4'h3, 1'b0, 1'b0);
        check("stall_drop", 32'(drop_o), 32'd1);
        check("stall_keep", 32'(word_o), 32'hD);
        step("stall_pulse", 0, 0, 0, 0, 0);
        check("stall_pulse_end", 32'(drop_o), 32'd0);

        // Ready in the completion cycle: D leaves, 3 loads, no drop
        step("hs_drain", 0, 0, 0, 0, 1);
        send_word("hs_D", 4'hD, 1'b0, 1'b0);
        step("hs_3a", 1, 1, 0, 0, 0);
        step("hs_3b", 1, 1, 0, 0, 0);
        step("hs_3c", 1, 0, 0, 0, 0);
        step("hs_3d", 1, 0, 0, 0, 1);
        check("hs_word", 32'(word_o), 32'h3);
        check("hs_vld",  32'(word_vld_o), 32'd1);
        check("hs_nodrop", 32'(drop_o), 32'd0);
        step("hs_drain2", 0, 0, 0, 0, 1);

        // Flush a partial word, including a bit that arrives with the flush
        step("fl0", 1, 1, 0, 0, 1);
        step("fl1", 1, 0, 0, 0, 1);
        step("fl_f", 1, 1, 0, 1, 1);
        check("fl_busy", 32'(busy_o), 32'd0);
        send_word("fl_E", 4'hE, 1'b0, 1'b1);
        check("fl_word", 32'(word_o), 32'hE);
        step("fl_drain", 0, 0, 0, 0, 1);

        // Async reset mid-word while a word is held
        send_word("rst_hold", 4'h9, 1'b1, 1'b0);
        step("rst_p0", 1, 1, 0, 0, 0);
        step("rst_p1", 1, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge clk);
        rst = 1'b0;
        send_word("rst_after", 4'h6, 1'b1, 1'b0);
        check("rst_after_word", 32'(word_o), 32'h6);
        step("rst_drain", 0, 0, 0, 0, 1);

        // Random traffic with gaps, flushes and back-pressure
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 3) != 0),
                 1'($urandom),
                 1'($urandom),
                 ($urandom_range(0, 19) == 0),
                 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
